i2c_init_sequencer: RTL and testbench

- Upstream command stage for the I2C master. Walks a table of register writes, timed delays and read-checks held in an external synchronous ROM, and issues one master transaction per entry.
- Typical use: power-up configuration of a sensor or codec, with completion and error status reported to system logic.
- Drives the master's enable/rw/data/reg-addr/device-addr inputs; consumes its busy and read-data outputs.

---
 rtl/i2c_init_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer
//
// Upstream command stage for the I2C master. It walks a table of register writes, timed delays
// and read-checks held in an external synchronous ROM and issues one master transaction per
// entry. It reports sticky completion and error status, plus the index of the first failing entry.
//
// ROM entry format: {op[1:0], reg[REG_WIDTH-1:0], data[DATA_WIDTH-1:0]}
//   op 00 WRITE : reg <- data
//   op 01 DELAY : wait data * DELAY_UNIT cycles (0 = no wait)
//   op 10 CHECK : read reg and compare with data
//   op 11 END   : sequence complete
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               one-cycle pulse, starts the sequence from entry 0 (ignored while busy)
//   i_device_addr         I2C device address used for every transaction
//   o_rom_addr            table read address
//   i_rom_data            table entry, valid one cycle after o_rom_addr changes
//   o_i2c_enable          master enable, held until master busy is seen high
//   o_i2c_rw              0 = write, 1 = read
//   o_i2c_reg_addr        master register address
//   o_i2c_mosi_data       master write data
//   o_i2c_device_addr     master device address
//   i_i2c_busy            master busy
//   i_i2c_miso_data       master read data
//   o_busy                sequence in progress
//   o_done                sticky, sequence ended normally
//   o_error               sticky, at least one timeout or read mismatch
//   o_err_index           entry index of the first error

module i2c_init_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned REG_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned ROM_AW     = 6,
  parameter int unsigned DELAY_UNIT = 1000,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic [ADDR_WIDTH-1:0]             i_device_addr,
  output logic [ROM_AW-1:0]                 o_rom_addr,
  input  logic [2+REG_WIDTH+DATA_WIDTH-1:0] i_rom_data,
  output logic                              o_i2c_enable,
  output logic                              o_i2c_rw,
  output logic [REG_WIDTH-1:0]              o_i2c_reg_addr,
  output logic [DATA_WIDTH-1:0]             o_i2c_mosi_data,
  output logic [ADDR_WIDTH-1:0]             o_i2c_device_addr,
  input  logic                              i_i2c_busy,
  input  logic [DATA_WIDTH-1:0]             i_i2c_miso_data,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_error,
  output logic [ROM_AW-1:0]                 o_err_index
);

  localparam int unsigned EntryW = 2 + REG_WIDTH + DATA_WIDTH;
  localparam int unsigned CntW   = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StReq,
    StXfer,
    StWaitDly,
    StNext,
    StFinish
  } state_e;

  typedef enum logic [1:0] {
    OpWrite = 2'b00,
    OpDelay = 2'b01,
    OpCheck = 2'b10,
    OpEnd   = 2'b11
  } op_e;

  state_e state_q, state_d;

  logic [ROM_AW-1:0]     rom_addr_q, rom_addr_d;
  logic                  fetch_ph_q, fetch_ph_d;
  logic [EntryW-1:0]     entry_q, entry_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic [REG_WIDTH-1:0]  reg_q, reg_d;
  logic [DATA_WIDTH-1:0] mosi_q, mosi_d;
  logic [ADDR_WIDTH-1:0] dev_q, dev_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ROM_AW-1:0]     err_idx_q, err_idx_d;

  op_e                   entry_op;
  logic [REG_WIDTH-1:0]  entry_reg;
  logic [DATA_WIDTH-1:0] entry_data;
  logic [CntW-1:0]       delay_load;
  logic                  tmo_hit;
  logic                  err_evt;

  assign entry_op   = op_e'(entry_q[EntryW-1 -: 2]);
  assign entry_reg  = entry_q[DATA_WIDTH +: REG_WIDTH];
  assign entry_data = entry_q[DATA_WIDTH-1:0];
  assign delay_load = CntW'(entry_data) * CntW'(DELAY_UNIT);

  // The same counter times both REQ and XFER; it restarts from 0 on entry to each.
  assign tmo_hit = (cnt_q == CntW'(TIMEOUT - 1));

  // Error sources: busy never rose, busy never fell, or a CHECK read back the wrong value.
  assign err_evt = ((state_q == StReq)  && !i_i2c_busy && tmo_hit) ||
                   ((state_q == StXfer) &&  i_i2c_busy && tmo_hit) ||
                   ((state_q == StXfer) && !i_i2c_busy && rw_q &&
                    (i_i2c_miso_data != mosi_q));

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (i_start) state_d = StFetch;
      end
      StFetch: begin
        if (fetch_ph_q) state_d = StDecode;
      end
      StDecode: begin
        case (entry_op)
          OpWrite, OpCheck: state_d = StReq;
          OpDelay:          state_d = (entry_data == '0) ? StNext : StWaitDly;
          default:          state_d = StFinish;
        endcase
      end
      StReq: begin
        if (i_i2c_busy)   state_d = StXfer;
        else if (tmo_hit) state_d = StNext;
      end
      StXfer: begin
        if (!i_i2c_busy || tmo_hit) state_d = StNext;
      end
      StWaitDly: begin
        if (cnt_q <= CntW'(1)) state_d = StNext;
      end
      StNext: begin
        // Running off the end of the table counts as END.
        state_d = (&rom_addr_q) ? StFinish : StFetch;
      end
      StFinish: begin
        // A start arriving here is dropped on purpose.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    o_i2c_enable = (state_q == StReq);
    o_busy       = (state_q != StIdle) && (state_q != StFinish);
  end

  // Datapath next-state
  always_comb begin
    rom_addr_d = rom_addr_q;
    fetch_ph_d = fetch_ph_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    reg_d      = reg_q;
    mosi_d     = mosi_q;
    dev_d      = dev_q;
    done_d     = done_q;
    error_d    = error_q;
    err_idx_d  = err_idx_q;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          rom_addr_d = '0;
          fetch_ph_d = 1'b0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_idx_d  = '0;
        end
      end
      StFetch: begin
        // Phase 0 covers the ROM read latency; phase 1 captures the entry.
        fetch_ph_d = ~fetch_ph_q;
        if (fetch_ph_q) entry_d = i_rom_data;
      end
      StDecode: begin
        case (entry_op)
          OpWrite, OpCheck: begin
            rw_d   = (entry_op == OpCheck);
            reg_d  = entry_reg;
            mosi_d = entry_data;
            dev_d  = i_device_addr;
            cnt_d  = '0;
          end
          OpDelay: cnt_d = delay_load;
          default: ;
        endcase
      end
      StReq: begin
        cnt_d = i_i2c_busy ? '0 : cnt_q + CntW'(1);
      end
      StXfer: begin
        cnt_d = cnt_q + CntW'(1);
      end
      StWaitDly: begin
        cnt_d = cnt_q - CntW'(1);
      end
      StNext: begin
        rom_addr_d = rom_addr_q + ROM_AW'(1);
      end
      default: ;
    endcase

    // Only the first error of a run is recorded.
    if (err_evt && !error_q) begin
      error_d   = 1'b1;
      err_idx_d = rom_addr_q;
    end

    if (state_d == StFinish) done_d = 1'b1;
  end

  // Datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rom_addr_q <= '0;
      fetch_ph_q <= 1'b0;
      entry_q    <= '0;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      reg_q      <= '0;
      mosi_q     <= '0;
      dev_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      fetch_ph_q <= fetch_ph_d;
      entry_q    <= entry_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      reg_q      <= reg_d;
      mosi_q     <= mosi_d;
      dev_q      <= dev_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign o_rom_addr        = rom_addr_q;
  assign o_i2c_rw          = rw_q;
  assign o_i2c_reg_addr    = reg_q;
  assign o_i2c_mosi_data   = mosi_q;
  assign o_i2c_device_addr = dev_q;
  assign o_done            = done_q;
  assign o_error           = error_q;
  assign o_err_index       = err_idx_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: synchronous ROM model, simple I2C master model, a table of
// whole-sequence scenarios, and hand-written sequences for delay timing, start filtering and
// reset during a transfer.

module tb_i2c_init_sequencer;

  localparam int unsigned RomAw     = 2;
  localparam int unsigned DelayUnit = 4;
  localparam int unsigned Timeout   = 50;
  localparam int unsigned Rise      = 3;
  localparam logic [6:0]  DevAddr   = 7'h42;
  localparam logic [1:0]  OpW = 2'b00, OpD = 2'b01, OpC = 2'b10, OpE = 2'b11;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_start = 1'b0;
  logic [6:0]       i_device_addr = DevAddr;
  logic [RomAw-1:0] o_rom_addr;
  logic [17:0]      i_rom_data;
  logic             o_i2c_enable;
  logic             o_i2c_rw;
  logic [7:0]       o_i2c_reg_addr;
  logic [7:0]       o_i2c_mosi_data;
  logic [6:0]       o_i2c_device_addr;
  logic             i_i2c_busy;
  logic [7:0]       i_i2c_miso_data;
  logic             o_busy;
  logic             o_done;
  logic             o_error;
  logic [RomAw-1:0] o_err_index;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  i2c_init_sequencer #(
    .DATA_WIDTH (8),
    .REG_WIDTH  (8),
    .ADDR_WIDTH (7),
    .ROM_AW     (RomAw),
    .DELAY_UNIT (DelayUnit),
    .TIMEOUT    (Timeout)
  ) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_start           (i_start),
    .i_device_addr     (i_device_addr),
    .o_rom_addr        (o_rom_addr),
    .i_rom_data        (i_rom_data),
    .o_i2c_enable      (o_i2c_enable),
    .o_i2c_rw          (o_i2c_rw),
    .o_i2c_reg_addr    (o_i2c_reg_addr),
    .o_i2c_mosi_data   (o_i2c_mosi_data),
    .o_i2c_device_addr (o_i2c_device_addr),
    .i_i2c_busy        (i_i2c_busy),
    .i_i2c_miso_data   (i_i2c_miso_data),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_error           (o_error),
    .o_err_index       (o_err_index)
  );

  // Synchronous ROM, one cycle read latency
  logic [17:0] rom [4];
  always @(posedge i_clk) i_rom_data <= rom[o_rom_addr];

  // Master model: busy rises Rise+1 cycles after an enable rising edge, stays high m_hold cycles,
  // then falls with the read data for that transaction. m_never marks transactions it ignores.
  logic            m_clr = 1'b0;
  logic [3:0]      m_never;
  logic [3:0][7:0] m_rd;
  int unsigned     m_hold;
  int              m_st;
  int unsigned     m_cnt;
  logic [1:0]      m_txn, m_cur;
  logic            en_d;

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst || m_clr) begin
      m_st <= 0; m_cnt <= 0; m_txn <= '0; m_cur <= '0; en_d <= 1'b0;
      i_i2c_busy <= 1'b0; i_i2c_miso_data <= '0;
    end else begin
      en_d <= o_i2c_enable;
      case (m_st)
        0: if (o_i2c_enable && !en_d) begin
             m_txn <= m_txn + 2'd1;
             if (!m_never[m_txn]) begin m_st <= 1; m_cnt <= 1; m_cur <= m_txn; end
           end
        1: if (m_cnt >= Rise) begin i_i2c_busy <= 1'b1; m_st <= 2; m_cnt <= 1; end
           else m_cnt <= m_cnt + 1;
        default: if (m_cnt >= m_hold) begin
                   i_i2c_busy <= 1'b0; i_i2c_miso_data <= m_rd[m_cur]; m_st <= 0;
                 end else m_cnt <= m_cnt + 1;
      endcase
    end
  end

  // Enable monitor: pulse count, fields and length of the first pulse
  int unsigned pulses, first_len;
  logic        en_prev;
  logic [23:0] first_txn;

  always @(negedge i_clk) begin
    if (m_clr) begin
      pulses = 0; first_len = 0; en_prev = 1'b0; first_txn = '0;
    end else begin
      if (o_i2c_enable && !en_prev) begin
        pulses++;
        if (pulses == 1)
          first_txn = {o_i2c_rw, o_i2c_reg_addr, o_i2c_mosi_data, o_i2c_device_addr};
      end
      if (o_i2c_enable && pulses == 1) first_len++;
      en_prev = o_i2c_enable;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] ent(input logic [1:0] op, input logic [7:0] r,
                                      input logic [7:0] d);
    return {op, r, d};
  endfunction

  typedef struct {
    string           name;
    logic [3:0][17:0] rom;
    logic [3:0]      never;
    logic [3:0][7:0] rd;
    int unsigned     hold;
    int unsigned     exp_pulses;
    logic            exp_error;
    logic [1:0]      exp_idx;
    logic [23:0]     exp_first;  // {rw, reg, data, dev}
    int unsigned     exp_len;    // 0: not checked
  } vec_t;

  localparam int NVec = 8;
  vec_t vecs[NVec];

  task automatic clear_model();
    @(negedge i_clk); #1 m_clr = 1'b1;
    @(negedge i_clk); #1 m_clr = 1'b0;
  endtask

  task automatic load(input int k);
    for (int e = 0; e < 4; e++) rom[e] = vecs[k].rom[e];
    m_never = vecs[k].never;
    m_rd    = vecs[k].rd;
    m_hold  = vecs[k].hold;
    clear_model();
  endtask

  task automatic pulse_start();
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
  endtask

  task automatic run_vec(input int k);
    string n;
    n = vecs[k].name;
    load(k);
    pulse_start();
    check({n, ".start_status"}, {o_busy, o_done, o_error}, 3'b100);
    for (int c = 0; c < 3000; c++) begin
      if (o_done) break;
      @(negedge i_clk);
    end
    check({n, ".done"}, o_done, 1'b1);
    repeat (40) @(negedge i_clk);
    check({n, ".busy_low"}, {o_busy, o_i2c_enable}, 2'b00);
    check({n, ".done_sticky"}, o_done, 1'b1);
    check({n, ".error"}, o_error, vecs[k].exp_error);
    check({n, ".err_index"}, o_err_index, vecs[k].exp_idx);
    check({n, ".pulses"}, pulses, vecs[k].exp_pulses);
    if (vecs[k].exp_pulses > 0) check({n, ".first_txn"}, first_txn, vecs[k].exp_first);
    if (vecs[k].exp_len > 0) check({n, ".enable_len"}, first_len, vecs[k].exp_len);
  endtask

  initial begin
    int n;
    int c;

    for (int k = 0; k < NVec; k++) begin
      for (int e = 0; e < 4; e++) vecs[k].rom[e] = ent(OpE, 8'h00, 8'h00);
      vecs[k].never = '0; vecs[k].rd = '0; vecs[k].hold = 40;
      vecs[k].exp_pulses = 0; vecs[k].exp_error = 1'b0; vecs[k].exp_idx = '0;
      vecs[k].exp_first = '0; vecs[k].exp_len = 0;
    end
    vecs[0].name = "write";
    vecs[0].rom[0] = ent(OpW, 8'h10, 8'hA5);
    vecs[0].exp_pulses = 1; vecs[0].exp_first = {1'b0, 8'h10, 8'hA5, DevAddr};

    vecs[1].name = "delay";
    vecs[1].rom[0] = ent(OpD, 8'h00, 8'd3);

    vecs[2].name = "check_mismatch";
    vecs[2].rom[0] = ent(OpC, 8'h20, 8'h5A);
    vecs[2].rom[1] = ent(OpC, 8'h21, 8'h00);
    vecs[2].rd[0] = 8'h5A; vecs[2].rd[1] = 8'h7F;
    vecs[2].exp_pulses = 2; vecs[2].exp_error = 1'b1; vecs[2].exp_idx = 2'd1;
    vecs[2].exp_first = {1'b1, 8'h20, 8'h5A, DevAddr};

    vecs[3].name = "req_timeout";
    vecs[3].rom[0] = ent(OpW, 8'h30, 8'h11);
    vecs[3].rom[1] = ent(OpW, 8'h31, 8'h22);
    vecs[3].never = 4'b0001;
    vecs[3].exp_pulses = 2; vecs[3].exp_error = 1'b1; vecs[3].exp_idx = 2'd0;
    vecs[3].exp_first = {1'b0, 8'h30, 8'h11, DevAddr}; vecs[3].exp_len = Timeout;

    vecs[4].name = "wrap_no_end";
    vecs[4].rom[0] = ent(OpW, 8'h40, 8'h01);
    vecs[4].rom[1] = ent(OpW, 8'h41, 8'h02);
    vecs[4].rom[2] = ent(OpW, 8'h42, 8'h03);
    vecs[4].rom[3] = ent(OpC, 8'h43, 8'h3C);
    vecs[4].rd[3] = 8'h3C;
    vecs[4].exp_pulses = 4; vecs[4].exp_first = {1'b0, 8'h40, 8'h01, DevAddr};

    vecs[5].name = "first_error_kept";
    vecs[5].rom[0] = ent(OpC, 8'h50, 8'hAA);
    vecs[5].rom[1] = ent(OpC, 8'h51, 8'hBB);
    vecs[5].exp_pulses = 2; vecs[5].exp_error = 1'b1; vecs[5].exp_idx = 2'd0;
    vecs[5].exp_first = {1'b1, 8'h50, 8'hAA, DevAddr};

    vecs[6].name = "xfer_timeout";
    vecs[6].rom[0] = ent(OpW, 8'h60, 8'h77);
    vecs[6].hold = 60;
    vecs[6].exp_pulses = 1; vecs[6].exp_error = 1'b1; vecs[6].exp_idx = 2'd0;
    vecs[6].exp_first = {1'b0, 8'h60, 8'h77, DevAddr};

    vecs[7].name = "end_only";

    // Reset state
    #1 i_rst = 1'b1;
    #1 check("reset_outputs",
             {o_rom_addr, o_i2c_enable, o_i2c_rw, o_i2c_reg_addr, o_i2c_mosi_data,
              o_i2c_device_addr, o_busy, o_done, o_error, o_err_index}, '0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_after_reset", {o_busy, o_done, o_i2c_enable}, 3'b000);

    for (int k = 0; k < NVec; k++) run_vec(k);

    // DELAY 3 x unit 4: 12 counting cycles plus 7 cycles of fetch/decode/next overhead.
    // A start pulse during the run must not disturb it.
    for (int e = 0; e < 4; e++) rom[e] = ent(OpE, 8'h00, 8'h00);
    rom[0] = ent(OpD, 8'h00, 8'd3);
    clear_model();
    pulse_start();
    n = 0;
    for (c = 0; c < 200; c++) begin
      if (!o_busy) break;
      n++;
      i_start = (n == 8);
      @(negedge i_clk);
    end
    i_start = 1'b0;
    check("delay3_busy_cycles", n, 19);
    check("delay3_no_enable", pulses, 0);
    check("delay3_done", {o_done, o_error}, 2'b10);

    // DELAY 0: no wait at all; a start in the FINISH cycle is dropped.
    rom[0] = ent(OpD, 8'h00, 8'd0);
    pulse_start();
    n = 0;
    for (c = 0; c < 200; c++) begin
      if (!o_busy) break;
      n++;
      @(negedge i_clk);
    end
    check("delay0_busy_cycles", n, 7);
    check("finish_cycle_done", o_done, 1'b1);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    check("start_in_finish_ignored", {o_busy, o_done}, 2'b01);

    // Reset during XFER, then a clean rerun from entry 0
    load(0);
    pulse_start();
    for (c = 0; c < 200; c++) begin
      if (i_i2c_busy) break;
      @(negedge i_clk);
    end
    check("xfer_reached", i_i2c_busy, 1'b1);
    repeat (2) @(negedge i_clk);
    #1 i_rst = 1'b1;
    #1 check("reset_mid_xfer_outputs",
             {o_rom_addr, o_i2c_enable, o_i2c_rw, o_i2c_reg_addr, o_i2c_mosi_data,
              o_i2c_device_addr, o_busy, o_done, o_error, o_err_index}, '0);
    @(negedge i_clk);
    i_rst = 1'b0;
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
